// File: rtl/ram8_bank_pkg.sv
// Shared memory definitions for the 8-word register bank.
package ram8_bank_pkg;

  localparam int unsigned DataWidth = 16;
  localparam int unsigned Depth     = 8;
  localparam int unsigned AddrWidth = $clog2(Depth);

  typedef logic [DataWidth-1:0] word_t;

endpackage : ram8_bank_pkg

// File: rtl/register_word.sv
// One storage word with load enable and asynchronous active-high clear.
module register_word
  import ram8_bank_pkg::*;
#(
  parameter int unsigned WIDTH = DataWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] word_q;

  // Clear on reset (takes priority), otherwise capture in when load is set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
    end else if (load) begin
      word_q <= in;
    end
  end

  assign out = word_q;

endmodule : register_word

// File: rtl/ram8_bank.sv
// 8-word register bank: decoded writes, combinational 8:1 read mux.
module ram8_bank
  import ram8_bank_pkg::*;
#(
  parameter int unsigned WIDTH = DataWidth,
  // The address port is fixed at 3 bits, so only the default depth is meaningful.
  parameter int unsigned DEPTH = Depth
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [AddrWidth-1:0] address,
  input  logic [WIDTH-1:0]     in,
  output logic [WIDTH-1:0]     out
);

  logic [DEPTH-1:0] word_load;
  logic [WIDTH-1:0] word_out [DEPTH];

  // Address decoder: at most one word sees its load enable.
  always_comb begin
    word_load = '0;
    if (load) begin
      word_load[address] = 1'b1;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    register_word #(
      .WIDTH (WIDTH)
    ) u_word (
      .clk   (clk),
      .reset (reset),
      .load  (word_load[i]),
      .in    (in),
      .out   (word_out[i])
    );
  end

  // Read mux: reflects stored contents only, never the incoming write data.
  always_comb begin
    out = word_out[address];
  end

endmodule : ram8_bank

// File: tb/tb_ram8_bank.sv
// Bench for ram8_bank: vector table plus scoreboard, with hand sequences for reset.
module tb_ram8_bank;

  logic        clk;
  logic        reset;
  logic        load;
  logic [2:0]  address;
  logic [15:0] in;
  logic [15:0] out;

  int unsigned n_tests;
  int unsigned n_failed;

  typedef struct {
    string       name;
    logic        load;
    logic [2:0]  addr;
    logic [15:0] din;
    logic [15:0] exp_pre;
    logic [15:0] exp_post;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] sb_q[$];

  ram8_bank u_dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .address (address),
    .in      (in),
    .out     (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic ld, input logic [2:0] a,
                         input logic [15:0] d, input logic [15:0] pre, input logic [15:0] post);
    vec_t v;
    v.name = name; v.load = ld; v.addr = a; v.din = d;
    v.exp_pre = pre; v.exp_post = post;
    vecs.push_back(v);
  endtask

  // Drive at the falling edge, check the pre-edge read, then score the post-edge read.
  task automatic apply(input vec_t v);
    logic [15:0] exp;
    @(negedge clk);
    load = v.load; address = v.addr; in = v.din;
    #1;
    check({v.name, "/pre"}, out, v.exp_pre);
    sb_q.push_back(v.exp_post);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_tests++; n_failed++;
      $display("FAIL %s/scoreboard: got empty queue, expected one entry", v.name);
    end else begin
      exp = sb_q.pop_front();
      check({v.name, "/post"}, out, exp);
    end
  endtask

  initial begin
    n_tests = 0; n_failed = 0;
    reset = 1'b1; load = 1'b0; address = '0; in = '0;

    // Reset sweep: everything reads zero.
    for (int k = 0; k < 8; k++) add_vec($sformatf("rst_sweep%0d", k), 1'b0, 3'(k), 16'hFFFF, 16'h0, 16'h0);
    // Sequential fill: two edges per address, in steps every two addresses.
    for (int i = 0; i < 16; i++)
      add_vec($sformatf("fill%0d", i), 1'b1, 3'(i / 2), 16'(i / 4),
              (i % 2 == 0) ? 16'h0 : 16'(i / 4), 16'(i / 4));
    // Hold: load low, in wiggling, contents unchanged (7 then 0 wraps naturally).
    for (int k = 0; k < 8; k++) add_vec($sformatf("hold%0d", k), 1'b0, 3'(k), 16'h5A00 + 16'(k), 16'(k / 2), 16'(k / 2));
    add_vec("hold_wrap0", 1'b0, 3'd0, 16'h1111, 16'h0, 16'h0);
    add_vec("hold_xin", 1'b0, 3'd2, 16'hxxxx, 16'h1, 16'h1);
    // Isolation.
    add_vec("iso_w3", 1'b1, 3'd3, 16'hBEEF, 16'h1, 16'hBEEF);
    add_vec("iso_w4", 1'b1, 3'd4, 16'h1234, 16'h2, 16'h1234);
    add_vec("iso_r0", 1'b0, 3'd0, 16'h0, 16'h0, 16'h0);
    add_vec("iso_r1", 1'b0, 3'd1, 16'h0, 16'h0, 16'h0);
    add_vec("iso_r2", 1'b0, 3'd2, 16'h0, 16'h1, 16'h1);
    add_vec("iso_r3", 1'b0, 3'd3, 16'h0, 16'hBEEF, 16'hBEEF);
    add_vec("iso_r4", 1'b0, 3'd4, 16'h0, 16'h1234, 16'h1234);
    add_vec("iso_r5", 1'b0, 3'd5, 16'h0, 16'h2, 16'h2);
    add_vec("iso_r6", 1'b0, 3'd6, 16'h0, 16'h3, 16'h3);
    add_vec("iso_r7", 1'b0, 3'd7, 16'h0, 16'h3, 16'h3);
    // Read-before-edge: no write-through.
    add_vec("rbe_w1", 1'b1, 3'd5, 16'h0001, 16'h2, 16'h0001);
    add_vec("rbe_wAA", 1'b1, 3'd5, 16'h00AA, 16'h0001, 16'h00AA);

    // One full cycle of reset, released at a falling edge.
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) apply(vecs[i]);

    // Asynchronous reset between edges, with no clock edge in between.
    @(negedge clk);
    load = 1'b0; address = 3'd5;
    #1;
    check("arst_before", out, 16'h00AA);
    #1;
    reset = 1'b1;
    #1;
    check("arst_immediate", out, 16'h0);
    for (int k = 0; k < 8; k++) begin
      address = 3'(k);
      #1;
      check($sformatf("arst_sweep%0d", k), out, 16'h0);
    end

    // Writes are ignored while reset is held.
    @(negedge clk);
    load = 1'b1; address = 3'd1; in = 16'hFFFF;
    @(posedge clk);
    #1;
    check("arst_write_ignored", out, 16'h0);

    // First write after release lands on the next edge; old data stays gone.
    @(negedge clk);
    reset = 1'b0; load = 1'b0;
    #1;
    check("post_rst_idle", out, 16'h0);
    begin
      vec_t v;
      v.name = "post_rst_w1"; v.load = 1'b1; v.addr = 3'd1; v.din = 16'h0F0F;
      v.exp_pre = 16'h0; v.exp_post = 16'h0F0F;
      apply(v);
      v.name = "post_rst_r3"; v.load = 1'b0; v.addr = 3'd3; v.din = 16'h0;
      v.exp_pre = 16'h0; v.exp_post = 16'h0;
      apply(v);
      v.name = "post_rst_r1"; v.load = 1'b0; v.addr = 3'd1; v.din = 16'hAAAA;
      v.exp_pre = 16'h0F0F; v.exp_post = 16'h0F0F;
      apply(v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule : tb_ram8_bank

// File: doc/ram8_bank.md
RAM8_BANK -- requirements
Module: ram8_bank

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 16, data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, number of words, fixed at 8 for this block, with the address width equal to log2(DEPTH)=3.

Ports:
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, the asynchronous active-high reset that clears all storage.
REQ-005 The block SHALL have port out, output, WIDTH bits, the contents of the word selected by address.
REQ-006 The block SHALL have port load, input, 1 bit, the write enable.
REQ-007 The block SHALL have port address, input, 3 bits, the word select for both read and write.
REQ-008 The block SHALL have port in, input, WIDTH bits, the write data.
REQ-009 The block SHALL use one clock, with reset asynchronous and active-high.

Function
REQ-010 The block SHALL store 8 independent words of WIDTH bits each.
REQ-011 On the rising clk edge with load=1 and reset=0, the block SHALL write in to word[address], and no other word SHALL change.
REQ-012 On the rising clk edge with load=0, no word SHALL change.
REQ-013 Read SHALL be combinational and asynchronous: out = word[address] at all times, with zero-cycle latency after an address change.
REQ-014 A write SHALL become visible on out immediately after the writing edge; in the same cycle before the edge, out SHALL show the old value, with no write-through of in.
REQ-015 All 8 addresses SHALL be valid, with no wrap-around logic beyond natural 3-bit arithmetic; address 7 followed by 0 SHALL select word 0.
REQ-016 Changes on in, address or load between clock edges SHALL NOT alter stored contents.
REQ-017 If address or in contains X or Z while load=1 at an edge, the stored result is unspecified; with load=0 at the edge, contents SHALL remain intact.

Reset
REQ-018 When reset=1, all 8 words SHALL clear to 0 immediately, without waiting for clk, and out SHALL read 0.
REQ-019 While reset=1, writes SHALL be ignored, because reset has priority over load.
REQ-020 After reset deasserts, the first write SHALL occur on the next rising clk edge with load=1.
REQ-021 A reset asserted in the middle of a write sequence SHALL discard all previously written data.

Structure
REQ-022 WIDTH and DEPTH defaults and the address width SHALL come from a shared memory package together with a word type of WIDTH bits.
REQ-023 The block SHALL be built from 8 instances of one sub-module, register_word, with ports clk, reset, load, in and out; register_word SHALL hold one WIDTH-bit word with load enable and asynchronous reset.
REQ-024 The block SHALL contain an address decoder that drives the load enable of exactly one register_word when load=1.
REQ-025 The block SHALL contain an 8:1 WIDTH-bit output multiplexer selected by address.

Verification
REQ-026 Reset scenario: set reset=1 for 1 cycle and sweep address 0..7 -> out=0x0000 for every address.
REQ-027 Sequential fill scenario: set load=1 with clk period 10 ns, address incrementing every 20 ns and in incrementing every 40 ns starting at 0 -> word k holds the in value present at its second write edge (word0=0, word1=0, word2=1, word3=1, ...), and out tracks each new value right after the edge.
REQ-028 Hold scenario: set load=0 and sweep address 0..7 while in changes -> out returns the previously stored values unchanged.
REQ-029 Isolation scenario: write 0xBEEF to address 3 and 0x1234 to address 4 -> read back 3=0xBEEF and 4=0x1234, with all other addresses unchanged.
REQ-030 Read-before-edge scenario: hold address 5 at value 0x0001, set in=0x00AA with load=1 -> out=0x0001 until the rising edge and 0x00AA after it.
REQ-031 Asynchronous reset scenario: assert reset between clock edges after a fill -> out=0 immediately with no clk edge, and all addresses read 0.
